// File: rtl/idct8_seq.sv
// Sequential 8-point inverse DCT: serial coefficients in, serial samples out,
// one time-multiplexed MAC against a constant cosine ROM.
module idct8_seq #(
    parameter int IN_W      = 18,
    parameter int OUT_W     = 9,
    parameter int COEF_FRAC = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned CW     = 15;
    localparam int unsigned ACC_W  = 36;
    localparam int unsigned PROD_W = CW + IN_W;

    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((longint'(1) << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    // C[n][k] = round(2^13 * a_k * cos((2n+1)k*pi/16)); angle folded into the first quadrant
    function automatic logic signed [CW-1:0] rom_coef(input logic [2:0] n, input logic [2:0] k);
        logic [4:0]             m;
        logic [3:0]             f;
        logic                   neg;
        logic signed [CW-1:0]   mag;
        m = 5'(7'({n, 1'b1}) * 7'(k));
        if (m <= 5'd8) begin
            f = 4'(m);
            neg = 1'b0;
        end else if (m <= 5'd16) begin
            f = 4'(5'd16 - m);
            neg = 1'b1;
        end else if (m <= 5'd24) begin
            f = 4'(m - 5'd16);
            neg = 1'b1;
        end else begin
            f = 4'(6'd32 - {1'b0, m});
            neg = 1'b0;
        end
        case (f)
            4'd0:    mag = 15'sd4096;
            4'd1:    mag = 15'sd4017;
            4'd2:    mag = 15'sd3784;
            4'd3:    mag = 15'sd3406;
            4'd4:    mag = 15'sd2896;
            4'd5:    mag = 15'sd2276;
            4'd6:    mag = 15'sd1567;
            4'd7:    mag = 15'sd799;
            default: mag = 15'sd0;
        endcase
        if (k == 3'd0) begin
            mag = 15'sd2896;
            neg = 1'b0;
        end
        return neg ? -mag : mag;
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              k_q, k_d, j_q, j_d, n_q, n_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [IN_W-1:0]  coef_q [8];
    logic signed [IN_W-1:0]  coef_d [8];
    logic                    in_ready_d, out_valid_d, out_last_d, busy_d;
    logic signed [OUT_W-1:0] out_data_d;

    logic signed [CW-1:0]     c_cur;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum, acc_rnd;
    logic signed [OUT_W-1:0]  sat_val;

    // MAC datapath: term j of sample n, then round-half-up and saturate
    always_comb begin
        c_cur   = rom_coef(n_q, j_q);
        prod    = PROD_W'(c_cur) * PROD_W'(coef_q[j_q]);
        acc_sum = ((j_q == 3'd0) ? '0 : acc_q) + ACC_W'(prod);
        acc_rnd = (acc_sum + RND_HALF) >>> COEF_FRAC;
        if (acc_rnd > SAT_MAX)      sat_val = OUT_W'(SAT_MAX);
        else if (acc_rnd < SAT_MIN) sat_val = OUT_W'(SAT_MIN);
        else                        sat_val = OUT_W'(acc_rnd);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        j_d         = j_q;
        n_d         = n_q;
        acc_d       = acc_q;
        coef_d      = coef_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        case (state_q)
            LOAD: begin
                if (in_valid && in_ready) begin
                    coef_d[k_q] = in_data;
                    if (k_q == 3'd7) begin
                        k_d     = 3'd0;
                        j_d     = 3'd0;
                        state_d = CALC;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            CALC: begin
                acc_d = acc_sum;
                if (j_q == 3'd7) begin
                    j_d         = 3'd0;
                    out_data_d  = sat_val;
                    out_valid_d = 1'b1;
                    out_last_d  = (n_q == 3'd7);
                    state_d     = EMIT;
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (n_q == 3'd7) begin
                        n_d     = 3'd0;
                        state_d = LOAD;
                    end else begin
                        n_d     = n_q + 3'd1;
                        state_d = CALC;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != LOAD) || (k_d != 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            k_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            for (int i = 0; i < 8; i++) coef_q[i] <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            coef_q    <= coef_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
        end
    end

endmodule
